// File: rtl/enc_3_6.sv
// Sequential greedy Fibonacci-number-system encoder: turns a binary word into a 9-bit
// weighted codeword MSB-first, one bit per clock, under a per-bit enable mask.
module enc_3_6 #(
   parameter int unsigned CW = 9,
   parameter int unsigned DW = 7,
   parameter int unsigned WW = 7
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] datain,
   input  logic [CW-1:0] en_flag,
   input  logic [WW-1:0] FNS03,
   input  logic [WW-1:0] FNS04,
   input  logic [WW-1:0] FNS05,
   input  logic [WW-1:0] FNS06,
   input  logic [WW-1:0] FNS07,
   input  logic [WW-1:0] FNS08,
   input  logic [WW-1:0] FNS09,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [CW-1:0] codeout,
   output logic          err
);

   localparam int unsigned IdxW = $clog2(CW);
   localparam int unsigned RemW = DW + 1;
   localparam int unsigned CmpW = (WW > RemW) ? WW : RemW;

   typedef enum logic [1:0] {StIdle, StEnc, StDone} state_e;

   state_e                state_q, state_d;
   logic [RemW-1:0]       rem_q, rem_d;
   logic [CW-1:0]         en_q, en_d;
   logic [CW-1:0]         code_q, code_d;
   logic [CW-1:0][WW-1:0] w_q, w_d;
   logic [IdxW-1:0]       idx_q, idx_d;
   logic                  in_ready_q, in_ready_d;
   logic                  out_valid_q, out_valid_d;
   logic                  err_q, err_d;
   logic [CmpW-1:0]       cur_w, rem_ext, diff;

   // Bits 0 and 1 carry a fixed weight of 1; slots 0/1 of w_q are never used.
   always_comb begin
      if (idx_q < IdxW'(2)) cur_w = CmpW'(1);
      else                  cur_w = CmpW'(w_q[idx_q]);
      rem_ext = CmpW'(rem_q);
      diff    = rem_ext - cur_w;
   end

   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      en_d        = en_q;
      code_d      = code_q;
      w_d         = w_q;
      idx_d       = idx_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      err_d       = err_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               rem_d      = RemW'(datain);
               en_d       = en_flag;
               w_d        = {FNS09, FNS08, FNS07, FNS06, FNS05, FNS04, FNS03, {(2*WW){1'b0}}};
               code_d     = '0;
               idx_d      = IdxW'(CW - 1);
               in_ready_d = 1'b0;
               state_d    = StEnc;
            end
         end
         StEnc: begin
            // Subtract only when it fits, so the residue can never underflow.
            if (en_q[idx_q] && (rem_ext >= cur_w)) begin
               code_d[idx_q] = 1'b1;
               rem_d         = RemW'(diff);
            end
            if (idx_q == '0) begin
               out_valid_d = 1'b1;
               err_d       = (rem_d != '0);
               state_d     = StDone;
            end else begin
               idx_d = idx_q - IdxW'(1);
            end
         end
         StDone: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = StIdle;
            end
         end
         default: begin
            state_d     = StIdle;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         rem_q       <= '0;
         en_q        <= '0;
         code_q      <= '0;
         w_q         <= '0;
         idx_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         en_q        <= en_d;
         code_q      <= code_d;
         w_q         <= w_d;
         idx_q       <= idx_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         err_q       <= err_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign codeout   = code_q;
   assign err       = err_q;

endmodule
